// File: rtl/ex_alu_seq_ctrl_if.sv
// Request/response handshake bundle between an op issuer (master) and the ALU sequencer (slave).
interface ex_alu_seq_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_update;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, req_update, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_update, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/ex_alu_seq_ctrl.sv
// Execute-stage ALU sequencer: single-cycle ops, iterative shift-add MUL, registered flags.
// Define EX_MUL_EARLY_TERM_EN to end MUL once the remaining multiplier bits are all zero.
module ex_alu_seq_ctrl #(
    parameter int         WIDTH  = 64,
    parameter logic [2:0] MUL_OP = 3'b111,
    parameter logic [2:0] ADD_OP = 3'b010
) (
    input  logic                clk,
    input  logic                reset,
    ex_alu_seq_ctrl_if.slave    bus,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [2:0]          alu_cntrl,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_neg,
    input  logic                alu_zero,
    input  logic                alu_ovf,
    input  logic                alu_cout,
    output logic                negative,
    output logic                zero,
    output logic                overflow,
    output logic                carry_out,
    output logic                busy
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   alu_a_r;
    logic [WIDTH-1:0]   alu_b_r;
    logic [2:0]         alu_cntrl_r;
    logic               update_r;
    logic [WIDTH-1:0]   resp_result_r;
    logic [3:0]         flags_r;
    logic               req_ready_r;
    logic               resp_valid_r;
    logic               busy_r;
    logic               accept_s;
    logic               mul_op_s;
    logic               mul_last_s;
    logic [WIDTH-1:0]   acc_next_s;

    // Handshake qualification, MUL step decode and next-state selection.
    always_comb begin
        next_state_s = state_r;
        accept_s     = (state_r == ST_IDLE) && req_ready_r && bus.req_valid;
        mul_op_s     = (bus.req_op == MUL_OP);
        // alu_a_r doubles as the accumulator and alu_b_r as the shifted multiplicand
        acc_next_s   = mplier_r[0] ? alu_result : alu_a_r;
`ifdef EX_MUL_EARLY_TERM_EN
        mul_last_s   = (mplier_r[WIDTH-1:1] == '0);
`else
        mul_last_s   = (cnt_r == CNT_W'(WIDTH - 1));
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = mul_op_s ? ST_MUL : ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: next_state_s = ST_DONE;
            ST_MUL: begin
                if (mul_last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (bus.resp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            req_ready_r  <= (next_state_s == ST_IDLE);
            resp_valid_r <= (next_state_s == ST_DONE);
            busy_r       <= (next_state_s != ST_IDLE);
        end
    end

    // Operand capture, ALU drive, MUL iteration, result and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r         <= '0;
            mplier_r      <= '0;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
            alu_cntrl_r   <= 3'b000;
            update_r      <= 1'b0;
            resp_result_r <= '0;
            flags_r       <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= '0;
                        update_r <= bus.req_update;
                        if (mul_op_s) begin
                            alu_a_r     <= '0;
                            alu_b_r     <= bus.req_a;
                            mplier_r    <= bus.req_b;
                            alu_cntrl_r <= ADD_OP;
                        end else begin
                            alu_a_r     <= bus.req_a;
                            alu_b_r     <= bus.req_b;
                            mplier_r    <= '0;
                            alu_cntrl_r <= bus.req_op;
                        end
                    end
                end
                ST_EXEC: begin
                    resp_result_r <= alu_result;
                    if (update_r) begin
                        flags_r <= {alu_neg, alu_zero, alu_ovf, alu_cout};
                    end
                    alu_a_r     <= '0;
                    alu_b_r     <= '0;
                    alu_cntrl_r <= 3'b000;
                end
                ST_MUL: begin
                    cnt_r    <= cnt_r + CNT_W'(1);
                    mplier_r <= mplier_r >> 1;
                    if (mul_last_s) begin
                        resp_result_r <= acc_next_s;
                        alu_a_r       <= '0;
                        alu_b_r       <= '0;
                        alu_cntrl_r   <= 3'b000;
                    end else begin
                        alu_a_r <= acc_next_s;
                        alu_b_r <= alu_b_r << 1;
                    end
                end
                ST_DONE: begin
                    update_r <= 1'b0;
                end
                default: begin
                    alu_a_r     <= '0;
                    alu_b_r     <= '0;
                    alu_cntrl_r <= 3'b000;
                end
            endcase
        end
    end

    assign alu_a           = alu_a_r;
    assign alu_b           = alu_b_r;
    assign alu_cntrl       = alu_cntrl_r;
    assign bus.req_ready   = req_ready_r;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_result = resp_result_r;
    assign negative        = flags_r[3];
    assign zero            = flags_r[2];
    assign overflow        = flags_r[1];
    assign carry_out       = flags_r[0];
    assign busy            = busy_r;
endmodule
